instr_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the single-cycle core. It takes the core's program counter, fetches the addressed word from an instruction memory with variable latency over a valid/ready request and response interface, and presents it to the core's instruction input. A one-entry buffer holds the last fetched word with its address tag, so repeated fetches of the same PC are served without a memory access. `o_instr_valid` tells the core when the instruction is usable, and the core stalls its PC update while it is low.

---
 rtl/instr_fetch.sv | 128 ++++++++++++
 tb/tb_instr_fetch.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: one-entry tagged buffer in front of a variable-latency
// instruction memory with valid/ready request and response channels.
module instr_fetch #(
    parameter int unsigned                    DATA_WIDTH_P = 32,
    parameter logic [DATA_WIDTH_P-1:0]        NOP_INSTR_P  = '0,
    parameter int unsigned                    CNT_WIDTH_P  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH_P-1:0] i_pc,
    input  logic                    i_flush,
    output logic [DATA_WIDTH_P-1:0] o_instr,
    output logic                    o_instr_valid,
    output logic                    o_fault,
    output logic                    o_imem_req_valid,
    output logic [DATA_WIDTH_P-1:0] o_imem_req_addr,
    input  logic                    i_imem_req_ready,
    input  logic                    i_imem_rsp_valid,
    input  logic [DATA_WIDTH_P-1:0] i_imem_rsp_data,
    output logic [CNT_WIDTH_P-1:0]  o_miss_count
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH_P-1:0] tag_q, tag_d;
    logic                    tag_valid_q, tag_valid_d;
    logic [DATA_WIDTH_P-1:0] data_buf_q, data_buf_d;
    logic [DATA_WIDTH_P-1:0] req_addr_q, req_addr_d;
    logic                    req_valid_q, req_valid_d;
    logic                    drop_q, drop_d;
    logic [CNT_WIDTH_P-1:0]  miss_count_q, miss_count_d;

    logic aligned;
    logic hit;

    // Hit path is purely combinational so a buffered PC costs zero cycles.
    always_comb begin
        aligned       = (i_pc[1:0] == 2'b00);
        hit           = !reset && (state_q == StIdle) && tag_valid_q && (tag_q == i_pc) &&
                        !i_flush && aligned;
        o_instr_valid = hit;
        o_instr       = hit ? data_buf_q : NOP_INSTR_P;
        o_fault       = !reset && !aligned;
    end

    // Next-state logic for the fetch FSM, buffer and miss counter.
    always_comb begin
        state_d      = state_q;
        tag_d        = tag_q;
        tag_valid_d  = tag_valid_q;
        data_buf_d   = data_buf_q;
        req_addr_d   = req_addr_q;
        req_valid_d  = req_valid_q;
        drop_d       = drop_q;
        miss_count_d = miss_count_q;

        unique case (state_q)
            StIdle: begin
                if (!hit && aligned && !i_flush) begin
                    req_addr_d  = i_pc;
                    req_valid_d = 1'b1;
                    state_d     = StReq;
                    if (miss_count_q != '1) begin
                        miss_count_d = miss_count_q + CNT_WIDTH_P'(1);
                    end
                end
            end
            StReq: begin
                // Request stays up (flush or not) until the memory takes it.
                if (i_imem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = StWait;
                end
            end
            StWait: begin
                if (i_imem_rsp_valid) begin
                    state_d = StIdle;
                    drop_d  = 1'b0;
                    if (!drop_q) begin
                        data_buf_d  = i_imem_rsp_data;
                        tag_d       = req_addr_q;
                        tag_valid_d = 1'b1;
                    end
                end else if (i_flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d     = StIdle;
                req_valid_d = 1'b0;
            end
        endcase

        // Flush beats a same-cycle response write.
        if (i_flush) begin
            tag_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tag_q        <= '0;
            tag_valid_q  <= 1'b0;
            data_buf_q   <= '0;
            req_addr_q   <= '0;
            req_valid_q  <= 1'b0;
            drop_q       <= 1'b0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            tag_q        <= tag_d;
            tag_valid_q  <= tag_valid_d;
            data_buf_q   <= data_buf_d;
            req_addr_q   <= req_addr_d;
            req_valid_q  <= req_valid_d;
            drop_q       <= drop_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign o_imem_req_valid = req_valid_q;
    assign o_imem_req_addr  = req_addr_q;
    assign o_miss_count     = miss_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: stimulus queues expected memory requests and
// delivered instructions; a monitor pops and compares when the DUT presents them.
module tb_instr_fetch;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_pc;
    logic        i_flush;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        o_fault;
    logic        o_imem_req_valid;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_req_ready;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic [15:0] o_miss_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_req[$];
    logic [63:0] exp_instr[$];  // {pc, instr}

    instr_fetch #(
        .DATA_WIDTH_P(32),
        .NOP_INSTR_P (Nop),
        .CNT_WIDTH_P (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .i_pc            (i_pc),
        .i_flush         (i_flush),
        .o_instr         (o_instr),
        .o_instr_valid   (o_instr_valid),
        .o_fault         (o_fault),
        .o_imem_req_valid(o_imem_req_valid),
        .o_imem_req_addr (o_imem_req_addr),
        .i_imem_req_ready(i_imem_req_ready),
        .i_imem_rsp_valid(i_imem_rsp_valid),
        .i_imem_rsp_data (i_imem_rsp_data),
        .o_miss_count    (o_miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares accepted requests and each new instruction delivery.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_pc    = '0;
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (o_imem_req_valid && i_imem_req_ready) begin
                    if (exp_req.size() == 0) chk("unexpected_req", 64'(o_imem_req_valid), 64'd0);
                    else chk("req_addr", 64'(o_imem_req_addr), 64'(exp_req.pop_front()));
                end
                if (o_instr_valid && !(prev_valid && prev_pc == i_pc)) begin
                    if (exp_instr.size() == 0) chk("unexpected_instr", 64'(o_instr_valid), 64'd0);
                    else chk("instr_delivery", {i_pc, o_instr}, exp_instr.pop_front());
                end
            end
            prev_valid = o_instr_valid;
            prev_pc    = i_pc;
        end
    end

    initial begin
        reset = 1'b1; i_pc = 32'h6; i_flush = 1'b0;
        i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0; i_imem_rsp_data = '0;

        // Reset state (misaligned PC must not fault while reset is high)
        tick();
        @(negedge clk);
        chk("rst_valid", 64'(o_instr_valid), 64'd0);
        chk("rst_instr", 64'(o_instr), 64'(Nop));
        chk("rst_fault", 64'(o_fault), 64'd0);
        chk("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
        chk("rst_req_addr", 64'(o_imem_req_addr), 64'd0);
        chk("rst_miss", 64'(o_miss_count), 64'd0);
        tick();

        // First fetch: minimum 3-cycle miss latency
        exp_req.push_back(32'h0);
        exp_instr.push_back({32'h0, 32'h2008_0005});
        reset = 1'b0; i_pc = 32'h0; i_imem_req_ready = 1'b1;
        @(negedge clk); chk("first_c0_valid", 64'(o_instr_valid), 64'd0);
        tick();
        @(negedge clk); chk("first_c1_valid", 64'(o_instr_valid), 64'd0);
        chk("first_c1_req", 64'(o_imem_req_valid), 64'd1);
        tick();
        i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h2008_0005;
        @(negedge clk); chk("first_c2_valid", 64'(o_instr_valid), 64'd0);
        tick();
        i_imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("first_c3_valid", 64'(o_instr_valid), 64'd1);
        chk("first_c3_instr", 64'(o_instr), 64'h2008_0005);
        chk("first_miss", 64'(o_miss_count), 64'd1);

        // Buffer hit for 5 more cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("hit_valid", 64'(o_instr_valid), 64'd1);
            chk("hit_no_req", 64'(o_imem_req_valid), 64'd0);
            chk("hit_miss", 64'(o_miss_count), 64'd1);
        end

        // Backpressure: ready low for 3 REQ cycles
        tick();
        exp_req.push_back(32'h4);
        exp_instr.push_back({32'h4, 32'h1111_0004});
        i_pc = 32'h4; i_imem_req_ready = 1'b0;
        @(negedge clk); chk("bp_c0_valid", 64'(o_instr_valid), 64'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_req_valid", 64'(o_imem_req_valid), 64'd1);
            chk("bp_req_addr", 64'(o_imem_req_addr), 64'h4);
            tick();
        end
        i_imem_req_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_valid_last", 64'(o_imem_req_valid), 64'd1);
        chk("bp_req_addr_last", 64'(o_imem_req_addr), 64'h4);
        tick();
        i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h1111_0004;
        @(negedge clk); chk("bp_wait_valid", 64'(o_instr_valid), 64'd0);
        tick();
        i_imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("bp_valid", 64'(o_instr_valid), 64'd1);
        chk("bp_instr", 64'(o_instr), 64'h1111_0004);
        chk("bp_miss", 64'(o_miss_count), 64'd2);

        // Flush in WAIT: response dropped, address 8 refetched
        tick();
        exp_req.push_back(32'h8);
        exp_req.push_back(32'h8);
        exp_instr.push_back({32'h8, 32'h8888_0008});
        i_pc = 32'h8;
        tick();                                   // REQ, accepted
        tick();                                   // WAIT
        i_flush = 1'b1;
        @(negedge clk); chk("fl_wait_valid", 64'(o_instr_valid), 64'd0);
        tick();
        i_flush = 1'b0; i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'hDEAD_BEEF;
        tick();
        i_imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fl_dropped_valid", 64'(o_instr_valid), 64'd0);
        chk("fl_dropped_instr", 64'(o_instr), 64'(Nop));
        tick();                                   // REQ again
        tick();                                   // WAIT
        i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h8888_0008;
        tick();
        i_imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fl_valid", 64'(o_instr_valid), 64'd1);
        chk("fl_instr", 64'(o_instr), 64'h8888_0008);
        chk("fl_miss", 64'(o_miss_count), 64'd4);

        // Misaligned PC: fault, no request
        tick();
        i_pc = 32'h6;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mis_fault", 64'(o_fault), 64'd1);
            chk("mis_valid", 64'(o_instr_valid), 64'd0);
            chk("mis_instr", 64'(o_instr), 64'(Nop));
            chk("mis_req", 64'(o_imem_req_valid), 64'd0);
            tick();
        end
        chk("mis_miss", 64'(o_miss_count), 64'd4);

        // PC change 12 -> 16 during WAIT
        exp_req.push_back(32'hC);
        exp_instr.push_back({32'hC, 32'hC00C_000C});
        exp_req.push_back(32'h10);
        exp_instr.push_back({32'h10, 32'h1616_0016});
        i_pc = 32'hC;
        @(negedge clk); chk("pc_fault", 64'(o_fault), 64'd0);
        tick();                                   // REQ
        tick();                                   // WAIT
        i_pc = 32'h10;
        @(negedge clk); chk("pc_wait_valid", 64'(o_instr_valid), 64'd0);
        tick();
        i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'hC00C_000C;
        @(negedge clk); chk("pc_rsp_valid", 64'(o_instr_valid), 64'd0);
        tick();
        i_imem_rsp_valid = 1'b0; i_pc = 32'hC;    // buffer must hold tag 12
        @(negedge clk);
        chk("pc_tag12_valid", 64'(o_instr_valid), 64'd1);
        chk("pc_tag12_instr", 64'(o_instr), 64'hC00C_000C);
        tick();
        i_pc = 32'h10;
        @(negedge clk); chk("pc16_miss_valid", 64'(o_instr_valid), 64'd0);
        tick();                                   // REQ 16
        @(negedge clk); chk("pc16_req_valid", 64'(o_instr_valid), 64'd0);
        tick();                                   // WAIT
        i_imem_rsp_valid = 1'b1; i_imem_rsp_data = 32'h1616_0016;
        @(negedge clk); chk("pc16_wait_valid", 64'(o_instr_valid), 64'd0);
        tick();
        i_imem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("pc16_valid", 64'(o_instr_valid), 64'd1);
        chk("pc16_instr", 64'(o_instr), 64'h1616_0016);
        chk("pc16_miss", 64'(o_miss_count), 64'd6);

        // Flush blocks a hit combinationally and invalidates the buffer
        tick();
        i_imem_req_ready = 1'b0; i_flush = 1'b1;
        @(negedge clk);
        chk("flush_hit_valid", 64'(o_instr_valid), 64'd0);
        chk("flush_hit_instr", 64'(o_instr), 64'(Nop));
        tick();
        @(negedge clk);
        chk("flush_no_req", 64'(o_imem_req_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);
        chk("instr_queue_empty", 64'(exp_instr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
